// File: rtl/uart_receptor.sv
// rtl/uart_receptor.sv - 16x-oversampled UART receiver; define RX_MAJORITY_VOTE_EN for 2-of-3 voting on data/stop bits
module uart_receptor #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err
);
    localparam int NB_NB = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam int NB_SI = (NB_STOP > 1) ? $clog2(NB_STOP) : 1;
    localparam logic [NB_NB-1:0] LAST_BIT  = NB_NB'(NB_DATA - 1);
    localparam logic [NB_SI-1:0] LAST_STOP = NB_SI'(NB_STOP - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [3:0]         cnt;
    logic [NB_NB-1:0]   n_bit;
    logic [NB_SI-1:0]   n_stop;
    logic [NB_DATA-1:0] shreg;
    logic               stop_err;
    logic               data_bit;
    logic               stop_bit;
    logic               stop_err_next;

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [3:0] STOP_DEC = 4'd8;
    logic [2:0] vote;
    // The stop decision is taken on the cnt=8 tick itself, so the third vote is the live sample.
    assign data_bit = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
    assign stop_bit = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
`else
    localparam logic [3:0] STOP_DEC = 4'd7;
    logic bit_s;
    assign data_bit = bit_s;
    assign stop_bit = rx_s;
`endif

    assign stop_err_next = stop_err | ~stop_bit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vote <= 3'b000;
        end else if (i_tick && (state == DATA || state == STOP)) begin
            if (cnt == 4'd6) vote[0] <= rx_s;
            if (cnt == 4'd7) vote[1] <= rx_s;
            if (cnt == 4'd8) vote[2] <= rx_s;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bit_s <= 1'b1;
        end else if (i_tick && state == DATA && cnt == 4'd7) begin
            bit_s <= rx_s;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            n_bit       <= '0;
            n_stop      <= '0;
            shreg       <= '0;
            stop_err    <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= 4'd0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7 && rx_s) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else if (cnt == 4'd15) begin
                            state <= DATA;
                            n_bit <= '0;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            shreg <= {data_bit, shreg[NB_DATA-1:1]};
                            if (n_bit == LAST_BIT) begin
                                state    <= STOP;
                                n_stop   <= '0;
                                stop_err <= 1'b0;
                            end else begin
                                n_bit <= n_bit + 1'b1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == STOP_DEC) begin
                            // Leave at mid-bit of the last stop so an early next start edge is caught.
                            if (n_stop == LAST_STOP) begin
                                state <= IDLE;
                                cnt   <= 4'd0;
                                if (stop_err_next) begin
                                    o_frame_err <= 1'b1;
                                end else begin
                                    o_valid <= 1'b1;
                                    o_data  <= shreg;
                                end
                            end else begin
                                stop_err <= stop_err_next;
                            end
                        end else if (cnt == 4'd15) begin
                            n_stop <= n_stop + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end
endmodule
